// File: rtl/prng_harvest.sv
// prng_harvest: harvests 128-bit samples from the LFSR PRNG stage.
// A two-state FSM (LOAD/RUN) drives the PRNG seed-load enable. A sample is
// taken every STRIDE shift cycles into a DEPTH-entry FIFO. Samples are
// delivered to the core as two 64-bit words, low half first.
// Optional build macro: PRNG_HARVEST_HEALTH_EN discards all-zero and repeated
// samples and raises a sticky health_err.
//
// Handshake: a word transfers on a cycle where rnd_valid && rnd_ready.
// rnd_valid never depends on rnd_ready. rnd_data holds steady while
// rnd_valid=1 and rnd_ready=0. Both outputs are registered, so there is no
// combinational path from rnd_ready to them.
module prng_harvest #(
  parameter int DEPTH  = 4,
  parameter int STRIDE = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         reseed,
  output logic         prng_en,
  input  logic [128:0] rand_num,
  input  logic         rand_num_valid,
  output logic [63:0]  rnd_data,
  output logic         rnd_valid,
  input  logic         rnd_ready,
  output logic         health_err,
  output logic         dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] STRIDE_C = 8'(STRIDE);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [7:0]     cnt;
  logic [127:0]   mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic           half, half_n;
  logic           full, sample_due, sample_ok, push, accept, pop;
  logic [127:0]   head;
  logic           out_valid_n;
  logic [63:0]    out_data_n;
  logic           unused_bits;

  // Bit 128 of the PRNG state bus carries nothing the harvester needs.
  assign unused_bits = rand_num[128];

  assign dbg_state = state;

  assign accept = rnd_valid && rnd_ready;
  // An entry leaves the FIFO only once its upper half has been accepted.
  assign pop    = accept && half;
  // Full is judged on the pointers at the start of the cycle, so a pop in
  // the same cycle never makes room for that cycle's push.
  assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A sample is due once STRIDE fresh bits have shifted in; reseed wins.
  assign sample_due = (state == S_RUN) && !reseed && (cnt == STRIDE_C) &&
                      rand_num_valid && !full;
  assign push = sample_due && sample_ok;

`ifdef PRNG_HARVEST_HEALTH_EN
  logic [127:0] last_sample;

  assign sample_ok = (rand_num[127:0] != '0) && (rand_num[127:0] != last_sample);

  // Track the last pushed sample and latch any health failure until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sample <= '0;
      health_err  <= 1'b0;
    end else begin
      if (reseed) begin
        last_sample <= '0;
      end else if (push) begin
        last_sample <= rand_num[127:0];
      end
      if (sample_due && !sample_ok) begin
        health_err <= 1'b1;
      end
    end
  end
`else
  assign sample_ok  = 1'b1;
  assign health_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_LOAD;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state and seed-load enable; LOAD lasts one cycle unless reseeded.
  // prng_en is masked by rst so it reads low while reset is held.
  always_comb begin
    state_n = state;
    prng_en = 1'b0;
    case (state)
      S_LOAD: begin
        prng_en = !rst;
        state_n = S_RUN;
      end
      S_RUN: begin
        state_n = S_RUN;
      end
      default: begin
        state_n = S_LOAD;
      end
    endcase
    if (reseed) begin
      state_n = S_LOAD;
    end
  end

  // Stride counter: saturates at STRIDE. It restarts at 1 on a sample edge
  // because the PRNG shifts on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reseed || state == S_LOAD) begin
      cnt <= '0;
    end else if (sample_due) begin
      cnt <= 8'd1;
    end else if (cnt != STRIDE_C) begin
      cnt <= cnt + 8'd1;
    end
  end

  // FIFO storage write; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= rand_num[127:0];
    end
  end

  // Next pointers, half-select and registered output word.
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    half_n   = half;
    if (reseed) begin
      wr_ptr_n = '0;
      rd_ptr_n = '0;
      half_n   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_n = wr_ptr + (AW+1)'(1);
      end
      if (accept) begin
        half_n = !half;
      end
      if (pop) begin
        rd_ptr_n = rd_ptr + (AW+1)'(1);
      end
    end
    // When the entry being written becomes the head, bypass the array.
    head = mem[rd_ptr_n[AW-1:0]];
    if (push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
      head = rand_num[127:0];
    end
    out_valid_n = (wr_ptr_n != rd_ptr_n);
    out_data_n  = '0;
    if (out_valid_n) begin
      out_data_n = half_n ? head[127:64] : head[63:0];
    end
  end

  // Pointer, half-select and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      half      <= 1'b0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      half      <= half_n;
      rnd_valid <= out_valid_n;
      rnd_data  <= out_data_n;
    end
  end

endmodule

// File: tb/tb_prng_harvest.sv
// Testbench for prng_harvest (DEPTH=4, STRIDE=4) with a small LFSR model
// (poly=0 makes it a plain left shift, so samples are easy to predict).
module tb_prng_harvest;

  localparam int DEPTH  = 4;
  localparam int STRIDE = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         reseed = 1'b0;
  logic         rnd_ready = 1'b0;
  logic         prng_en, rnd_valid, health_err, dbg_state;
  logic [63:0]  rnd_data;
  logic [128:0] rand_num;
  logic [127:0] seed, poly, prng_state;
  logic         prng_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic        en;
    logic        v;
    logic [63:0] d;
  } vec_t;
  vec_t tbl[12];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // PRNG stage model: load seed on en, otherwise shift with feedback poly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prng_state <= '0;
      prng_valid <= 1'b0;
    end else if (prng_en) begin
      prng_state <= seed;
      prng_valid <= 1'b1;
    end else begin
      prng_state <= {prng_state[126:0], 1'b0} ^ (prng_state[127] ? poly : '0);
    end
  end
  assign rand_num = {1'b0, prng_state};

  prng_harvest #(.DEPTH(DEPTH), .STRIDE(STRIDE)) dut (
    .clk(clk),
    .rst(rst),
    .reseed(reseed),
    .prng_en(prng_en),
    .rand_num(rand_num),
    .rand_num_valid(prng_valid),
    .rnd_data(rnd_data),
    .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready),
    .health_err(health_err),
    .dbg_state(dbg_state)
  );

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_prng_en"}, 64'(prng_en), 64'd0);
    check({tag, "_rnd_valid"}, 64'(rnd_valid), 64'd0);
    check({tag, "_rnd_data"}, rnd_data, 64'd0);
    check({tag, "_health_err"}, 64'(health_err), 64'd0);
  endtask

  // Called in cycle 0 after reset release; walks cycles 0..11.
  task automatic run_release_table(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      check($sformatf("%s_c%0d_en", tag, i), 64'(prng_en), 64'(tbl[i].en));
      check($sformatf("%s_c%0d_valid", tag, i), 64'(rnd_valid), 64'(tbl[i].v));
      if (tbl[i].v) check($sformatf("%s_c%0d_data", tag, i), rnd_data, tbl[i].d);
    end
  endtask

  initial begin
    // Seed 1, shift by one per cycle: samples are 1<<4, 1<<8, ...
    for (int i = 0; i < 12; i++) tbl[i] = '{en: 1'b0, v: 1'b0, d: 64'h0};
    tbl[0].en = 1'b1;
    tbl[6]  = '{en: 1'b0, v: 1'b1, d: 64'h10};
    tbl[7]  = '{en: 1'b0, v: 1'b1, d: 64'h0};
    tbl[10] = '{en: 1'b0, v: 1'b1, d: 64'h100};
    tbl[11] = '{en: 1'b0, v: 1'b1, d: 64'h0};

    seed = 128'h1;
    poly = 128'h0;
    rnd_ready = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    check_reset_values("rst_hold");

    // Reset release and first samples.
    rst = 1'b0;
    #1;
    run_release_table("rel");

    // Backpressure: fill the FIFO, then drain with a same-cycle push/pop.
    rnd_ready = 1'b0;
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    check("bp_load_en", 64'(prng_en), 64'd1);
    step();
    check("bp_en_drop", 64'(prng_en), 64'd0);
    repeat (19) step();
    check("bp_mid_valid", 64'(rnd_valid), 64'd1);
    check("bp_mid_data", rnd_data, 64'h10);
    repeat (20) step();
    check("bp_hold_valid", 64'(rnd_valid), 64'd1);
    check("bp_hold_data", rnd_data, 64'h10);
    // Entries stored while stalled, then deferred pushes of 1<<41 and 1<<45.
    exp_q.push_back(64'h10);              exp_q.push_back(64'h0);
    exp_q.push_back(64'h100);             exp_q.push_back(64'h0);
    exp_q.push_back(64'h1000);            exp_q.push_back(64'h0);
    exp_q.push_back(64'h10000);           exp_q.push_back(64'h0);
    exp_q.push_back(64'h0000_0200_0000_0000); exp_q.push_back(64'h0);
    exp_q.push_back(64'h0000_2000_0000_0000); exp_q.push_back(64'h0);
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("bp_valid%0d", i), 64'(rnd_valid), 64'd1);
      if (rnd_valid && exp_q.size() > 0) begin
        check($sformatf("bp_word%0d", i), rnd_data, exp_q.pop_front());
      end
      step();
    end
    check("bp_queue_left", 64'(exp_q.size()), 64'd0);

    // Reseed while the upper half of an entry is pending.
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    check("rs_load_en", 64'(prng_en), 64'd1);
    repeat (6) step();
    check("rs_lo_valid", 64'(rnd_valid), 64'd1);
    check("rs_lo_data", rnd_data, 64'h10);
    step();
    check("rs_hi_valid", 64'(rnd_valid), 64'd1);
    check("rs_hi_data", rnd_data, 64'h0);
    rnd_ready = 1'b0;
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    check("rs_flush_valid", 64'(rnd_valid), 64'd0);
    check("rs_reload_en", 64'(prng_en), 64'd1);
    step();
    check("rs_en_low", 64'(prng_en), 64'd0);
    repeat (4) step();
    check("rs_c5_valid", 64'(rnd_valid), 64'd0);
    step();
    check("rs_c6_valid", 64'(rnd_valid), 64'd1);
    check("rs_c6_data", rnd_data, 64'h10);
    rnd_ready = 1'b1;

    // All-zero seed: health discard or zero words depending on the build.
    seed = 128'h0;
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    check("hz_load_en", 64'(prng_en), 64'd1);
    repeat (5) step();
    check("hz_c5_err", 64'(health_err), 64'd0);
    check("hz_c5_valid", 64'(rnd_valid), 64'd0);
    step();
`ifdef PRNG_HARVEST_HEALTH_EN
    check("hz_c6_err", 64'(health_err), 64'd1);
    check("hz_c6_valid", 64'(rnd_valid), 64'd0);
`else
    check("hz_c6_err", 64'(health_err), 64'd0);
    check("hz_c6_valid", 64'(rnd_valid), 64'd1);
    check("hz_c6_data", rnd_data, 64'h0);
`endif
    repeat (5) step();
`ifdef PRNG_HARVEST_HEALTH_EN
    check("hz_c11_err", 64'(health_err), 64'd1);
    check("hz_c11_valid", 64'(rnd_valid), 64'd0);
`else
    check("hz_c11_err", 64'(health_err), 64'd0);
    check("hz_c11_valid", 64'(rnd_valid), 64'd1);
    check("hz_c11_data", rnd_data, 64'h0);
`endif

    // Reset asserted mid-stream, then the LOAD sequence replays.
    seed = 128'h1;
    reseed = 1'b1;
    step();
    reseed = 1'b0;
    repeat (6) step();
    check("mr_pre_valid", 64'(rnd_valid), 64'd1);
    check("mr_pre_data", rnd_data, 64'h10);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("mr_async");
    step();
    step();
    rst = 1'b0;
    #1;
    run_release_table("rel2");
    check("rel2_err", 64'(health_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
